// File: rtl/serdes_pattern_chk_if.sv
// Fabric-side bundle for the SERDES pattern generator/checker: control, TX words out, RX words in, status.
// The checker binds to the slave modport; the fabric or bench uses the master modport.
interface serdes_pattern_chk_if #(
  parameter int unsigned BYTES     = 8,
  parameter int unsigned ERR_CNT_W = 16
);
  logic                   en_i;
  logic [1:0]             mode_i;
  logic                   force_err_i;
  logic                   cnt_clr_i;
  logic [8*BYTES-1:0]     tx_data_o;
  logic [BYTES-1:0]       tx_char_is_k_o;
  logic [8*BYTES-1:0]     rx_data_i;
  logic [BYTES-1:0]       rx_char_is_k_i;
  logic [BYTES-1:0]       rx_not_in_table_i;
  logic [BYTES-1:0]       rx_disp_err_i;
  logic                   locked_o;
  logic                   err_o;
  logic [ERR_CNT_W-1:0]   err_cnt_o;
  logic [31:0]            word_cnt_o;

  modport slave (
    input  en_i, mode_i, force_err_i, cnt_clr_i,
    input  rx_data_i, rx_char_is_k_i, rx_not_in_table_i, rx_disp_err_i,
    output tx_data_o, tx_char_is_k_o, locked_o, err_o, err_cnt_o, word_cnt_o
  );

  modport master (
    output en_i, mode_i, force_err_i, cnt_clr_i,
    output rx_data_i, rx_char_is_k_i, rx_not_in_table_i, rx_disp_err_i,
    input  tx_data_o, tx_char_is_k_o, locked_o, err_o, err_cnt_o, word_cnt_o
  );
endinterface

// File: rtl/serdes_pattern_chk.sv
// SERDES test-pattern generator (comma / counting / PRBS-7) and RX checker with lock FSM
// and saturating error and word counters. TX and RX share trx_clk_i.
module serdes_pattern_chk #(
  parameter int unsigned BYTES     = 8,
  parameter logic [7:0]  COMMA_K   = 8'hBC,
  parameter logic [7:0]  FILL      = 8'h4A,
  parameter int unsigned K_POS     = 0,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned LOCK_GOOD = 8,
  parameter int unsigned LOCK_BAD  = 4
) (
  input  logic               trx_clk_i,
  input  logic               trx_rst_i,
  serdes_pattern_chk_if.slave bus
);

  localparam int unsigned W    = 8 * BYTES;
  localparam int unsigned GC_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned BC_W = $clog2(LOCK_BAD + 1);
  localparam logic [7:0]      STEP      = 8'(BYTES);
  localparam logic [GC_W-1:0] GOOD_LAST = GC_W'(LOCK_GOOD - 1);
  localparam logic [BC_W-1:0] BAD_LAST  = BC_W'(LOCK_BAD - 1);
  localparam logic [6:0]      PRBS_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [W-1:0] fixed_word();
    logic [W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i == K_POS) d[8*i +: 8] = COMMA_K;
      else            d[8*i +: 8] = FILL;
    end
    return d;
  endfunction

  function automatic logic [W-1:0] count_word(input logic [7:0] seq);
    logic [W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < BYTES; i++) d[8*i +: 8] = seq + 8'(i);
    return d;
  endfunction

  // Runs W PRBS-7 steps; returns {next_state, word} with bit 0 produced first.
  function automatic logic [W+6:0] prbs_step(input logic [6:0] seed);
    logic [6:0]   s;
    logic [W-1:0] d;
    logic         nb;
    s = seed;
    d = '0;
    for (int unsigned j = 0; j < W; j++) begin
      nb   = s[6] ^ s[5];
      d[j] = nb;
      s    = {s[5:0], nb};
    end
    return {s, d};
  endfunction

  // The newest received bit sits in s[0], matching the generator's shift direction.
  function automatic logic [6:0] prbs_tail(input logic [W-1:0] d);
    logic [6:0] s;
    for (int unsigned k = 0; k < 7; k++) s[k] = d[W-1-k];
    return s;
  endfunction

  localparam logic [W-1:0]     FIXED_WORD = fixed_word();
  localparam logic [BYTES-1:0] FIXED_K    = {{(BYTES-1){1'b0}}, 1'b1} << K_POS;

  logic [W-1:0]         tx_data_r;
  logic [BYTES-1:0]     tx_k_r;
  logic [7:0]           seq_r;
  logic [6:0]           prbs_tx_r;
  state_t               state_r;
  logic                 locked_r;
  logic                 err_r;
  logic [GC_W-1:0]      good_cnt_r;
  logic [BC_W-1:0]      bad_cnt_r;
  logic [7:0]           exp_seq_r;
  logic [6:0]           prbs_rx_r;
  logic                 en_prev_r;
  logic [1:0]           mode_prev_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic [31:0]          word_cnt_r;

  logic [1:0]           mode_eff_s;
  logic [W+6:0]         prbs_tx_res_s;
  logic [W+6:0]         prbs_rx_res_s;
  logic [W-1:0]         gen_data_s;
  logic [BYTES-1:0]     gen_k_s;
  logic [7:0]           seq_nxt_s;
  logic [6:0]           prbs_tx_nxt_s;
  logic [W-1:0]         exp_data_s;
  logic [BYTES-1:0]     exp_k_s;
  logic                 word_bad_s;
  logic                 mode_chg_s;
  logic [7:0]           seed_seq_s;
  logic [6:0]           seed_prbs_s;
  logic                 cnt_word_s;
  logic                 cnt_err_s;

  assign prbs_tx_res_s = prbs_step(prbs_tx_r);
  assign prbs_rx_res_s = prbs_step(prbs_rx_r);
  assign seed_seq_s    = bus.rx_data_i[7:0] + STEP;
  assign seed_prbs_s   = prbs_tail(bus.rx_data_i);

  // Reserved mode 3 behaves as fixed comma.
  always_comb begin
    if (bus.mode_i == 2'd3) mode_eff_s = 2'd0;
    else                    mode_eff_s = bus.mode_i;
  end

  // Next TX word and generator state for the selected pattern.
  always_comb begin
    gen_data_s    = FIXED_WORD;
    gen_k_s       = FIXED_K;
    seq_nxt_s     = seq_r;
    prbs_tx_nxt_s = prbs_tx_r;
    case (mode_eff_s)
      2'd1: begin
        gen_data_s = count_word(seq_r);
        gen_k_s    = '0;
        seq_nxt_s  = seq_r + STEP;
      end
      2'd2: begin
        gen_data_s    = prbs_tx_res_s[W-1:0];
        gen_k_s       = '0;
        prbs_tx_nxt_s = prbs_tx_res_s[W+6:W];
      end
      default: begin
        gen_data_s = FIXED_WORD;
        gen_k_s    = FIXED_K;
      end
    endcase
  end

  // Expected RX word and per-word error decision.
  always_comb begin
    exp_data_s = FIXED_WORD;
    exp_k_s    = FIXED_K;
    case (mode_eff_s)
      2'd1: begin
        exp_data_s = count_word(exp_seq_r);
        exp_k_s    = '0;
      end
      2'd2: begin
        exp_data_s = prbs_rx_res_s[W-1:0];
        exp_k_s    = '0;
      end
      default: begin
        exp_data_s = FIXED_WORD;
        exp_k_s    = FIXED_K;
      end
    endcase
    word_bad_s = (bus.rx_data_i != exp_data_s) || (bus.rx_char_is_k_i != exp_k_s) ||
                 (|bus.rx_not_in_table_i) || (|bus.rx_disp_err_i);
    mode_chg_s = bus.en_i && en_prev_r && (mode_eff_s != mode_prev_r);
  end

  // Counter increment qualifiers: only words seen while locked are counted.
  always_comb begin
    if (bus.en_i && !mode_chg_s && (state_r == ST_LOCKED)) cnt_word_s = 1'b1;
    else                                                   cnt_word_s = 1'b0;
    cnt_err_s = cnt_word_s & word_bad_s;
  end

  // TX pattern register; force_err only touches the output word, never the generator state.
  always_ff @(posedge trx_clk_i or posedge trx_rst_i) begin
    if (trx_rst_i) begin
      tx_data_r <= '0;
      tx_k_r    <= '0;
      seq_r     <= 8'h00;
      prbs_tx_r <= PRBS_SEED;
    end else if (bus.en_i) begin
      tx_data_r <= gen_data_s ^ {{(W-1){1'b0}}, bus.force_err_i};
      tx_k_r    <= gen_k_s;
      seq_r     <= seq_nxt_s;
      prbs_tx_r <= prbs_tx_nxt_s;
    end else begin
      tx_data_r <= '0;
      tx_k_r    <= '0;
    end
  end

  // Lock FSM: reseeds the expectation while searching, free-runs it once locked.
  always_ff @(posedge trx_clk_i or posedge trx_rst_i) begin
    if (trx_rst_i) begin
      state_r     <= ST_IDLE;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      good_cnt_r  <= '0;
      bad_cnt_r   <= '0;
      exp_seq_r   <= 8'h00;
      prbs_rx_r   <= PRBS_SEED;
      en_prev_r   <= 1'b0;
      mode_prev_r <= 2'd0;
    end else begin
      en_prev_r   <= bus.en_i;
      mode_prev_r <= mode_eff_s;
      err_r       <= 1'b0;
      if (!bus.en_i) begin
        state_r    <= ST_IDLE;
        locked_r   <= 1'b0;
        good_cnt_r <= '0;
        bad_cnt_r  <= '0;
      end else if (mode_chg_s) begin
        state_r    <= ST_SEARCH;
        locked_r   <= 1'b0;
        good_cnt_r <= '0;
        bad_cnt_r  <= '0;
        exp_seq_r  <= seed_seq_s;
        prbs_rx_r  <= seed_prbs_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_SEARCH;
          end
          ST_SEARCH: begin
            exp_seq_r <= seed_seq_s;
            prbs_rx_r <= seed_prbs_s;
            if (word_bad_s) begin
              good_cnt_r <= '0;
            end else if (good_cnt_r == GOOD_LAST) begin
              state_r    <= ST_LOCKED;
              locked_r   <= 1'b1;
              good_cnt_r <= '0;
            end else begin
              good_cnt_r <= good_cnt_r + GC_W'(1'b1);
            end
          end
          ST_LOCKED: begin
            exp_seq_r <= exp_seq_r + STEP;
            prbs_rx_r <= prbs_rx_res_s[W+6:W];
            if (word_bad_s) begin
              err_r <= 1'b1;
              if (bad_cnt_r == BAD_LAST) begin
                state_r   <= ST_SEARCH;
                locked_r  <= 1'b0;
                bad_cnt_r <= '0;
              end else begin
                bad_cnt_r <= bad_cnt_r + BC_W'(1'b1);
              end
            end else begin
              bad_cnt_r <= '0;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge trx_clk_i or posedge trx_rst_i) begin
    if (trx_rst_i) begin
      err_cnt_r  <= '0;
      word_cnt_r <= 32'd0;
    end else if (bus.cnt_clr_i) begin
      err_cnt_r  <= '0;
      word_cnt_r <= 32'd0;
    end else begin
      if (cnt_word_s && (word_cnt_r != 32'hFFFF_FFFF)) word_cnt_r <= word_cnt_r + 32'd1;
      if (cnt_err_s && (err_cnt_r != '1))              err_cnt_r  <= err_cnt_r + ERR_CNT_W'(1'b1);
    end
  end

  assign bus.tx_data_o      = tx_data_r;
  assign bus.tx_char_is_k_o = tx_k_r;
  assign bus.locked_o       = locked_r;
  assign bus.err_o          = err_r;
  assign bus.err_cnt_o      = err_cnt_r;
  assign bus.word_cnt_o     = word_cnt_r;

endmodule

// File: tb/tb_serdes_pattern_chk.sv
// Directed bench for serdes_pattern_chk: 8-byte fixed-mode loopback, 4-byte counting/saturation, 2-byte PRBS-7.
module tb_serdes_pattern_chk;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serdes_pattern_chk_if #(.BYTES(8), .ERR_CNT_W(16)) if8 ();
  serdes_pattern_chk_if #(.BYTES(4), .ERR_CNT_W(4))  if4 ();
  serdes_pattern_chk_if #(.BYTES(2), .ERR_CNT_W(16)) if2 ();

  serdes_pattern_chk #(.BYTES(8), .ERR_CNT_W(16)) u_dut8 (.trx_clk_i(clk), .trx_rst_i(rst), .bus(if8.slave));
  serdes_pattern_chk #(.BYTES(4), .ERR_CNT_W(4))  u_dut4 (.trx_clk_i(clk), .trx_rst_i(rst), .bus(if4.slave));
  serdes_pattern_chk #(.BYTES(2), .ERR_CNT_W(16)) u_dut2 (.trx_clk_i(clk), .trx_rst_i(rst), .bus(if2.slave));

  // Two-cycle TX->RX loopback for the 8-byte and 2-byte instances.
  logic [63:0] p8_d1, p8_d2;
  logic [7:0]  p8_k1, p8_k2;
  logic [15:0] p2_d1, p2_d2;
  logic [1:0]  p2_k1, p2_k2;
  logic        corrupt8, flip2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p8_d1 <= '0; p8_d2 <= '0; p8_k1 <= '0; p8_k2 <= '0;
      p2_d1 <= '0; p2_d2 <= '0; p2_k1 <= '0; p2_k2 <= '0;
    end else begin
      p8_d1 <= if8.tx_data_o; p8_d2 <= p8_d1; p8_k1 <= if8.tx_char_is_k_o; p8_k2 <= p8_k1;
      p2_d1 <= if2.tx_data_o; p2_d2 <= p2_d1; p2_k1 <= if2.tx_char_is_k_o; p2_k2 <= p2_k1;
    end
  end

  assign if8.rx_data_i         = p8_d2;
  assign if8.rx_char_is_k_i    = p8_k2;
  assign if8.rx_not_in_table_i = 8'h00;
  assign if8.rx_disp_err_i     = {7'b0, corrupt8};
  assign if2.rx_data_i         = p2_d2 ^ {15'b0, flip2};
  assign if2.rx_char_is_k_i    = p2_k2;
  assign if2.rx_not_in_table_i = 2'b00;
  assign if2.rx_disp_err_i     = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive4(input int w);
    logic [7:0] b;
    b = 8'hF7 + 8'(4 * w);
    if4.rx_data_i = {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endtask

  // Independent PRBS-7 model: {next_state, 16-bit word}, bit 0 generated first.
  function automatic logic [22:0] prbs16(input logic [6:0] st);
    logic [15:0] d;
    logic [6:0]  s;
    s = st;
    for (int j = 0; j < 16; j++) begin
      d[j] = s[6] ^ s[5];
      s    = {s[5:0], d[j]};
    end
    return {s, d};
  endfunction

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        frc;
    logic [31:0] data;
    logic [3:0]  k;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int         pulses;
    int         w4;
    logic [22:0] m;

    tbl[0] = '{1'b0, 2'd0, 1'b0, 32'h0000_0000, 4'h0};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 32'h4A4A_4ABC, 4'h1};
    tbl[2] = '{1'b1, 2'd3, 1'b0, 32'h4A4A_4ABC, 4'h1};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h0302_0100, 4'h0};
    tbl[4] = '{1'b1, 2'd1, 1'b0, 32'h0706_0504, 4'h0};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 32'h0B0A_0909, 4'h0};
    tbl[6] = '{1'b1, 2'd1, 1'b0, 32'h0F0E_0D0C, 4'h0};
    tbl[7] = '{1'b1, 2'd0, 1'b1, 32'h4A4A_4ABD, 4'h1};
    tbl[8] = '{1'b0, 2'd1, 1'b0, 32'h0000_0000, 4'h0};
    tbl[9] = '{1'b1, 2'd1, 1'b0, 32'h1312_1110, 4'h0};

    rst = 1'b1;
    corrupt8 = 1'b0; flip2 = 1'b0;
    if8.en_i = 1'b0; if8.mode_i = 2'd0; if8.force_err_i = 1'b0; if8.cnt_clr_i = 1'b0;
    if2.en_i = 1'b0; if2.mode_i = 2'd0; if2.force_err_i = 1'b0; if2.cnt_clr_i = 1'b0;
    if4.en_i = 1'b0; if4.mode_i = 2'd0; if4.force_err_i = 1'b0; if4.cnt_clr_i = 1'b0;
    if4.rx_data_i = '0; if4.rx_char_is_k_i = '0; if4.rx_not_in_table_i = '0; if4.rx_disp_err_i = '0;
    tick(2);
    chk("rst_tx_data",  if8.tx_data_o, 64'h0);
    chk("rst_tx_k",     64'(if8.tx_char_is_k_o), 64'h0);
    chk("rst_locked",   64'(if8.locked_o), 64'h0);
    chk("rst_err",      64'(if8.err_o), 64'h0);
    chk("rst_err_cnt",  64'(if8.err_cnt_o), 64'h0);
    chk("rst_word_cnt", 64'(if8.word_cnt_o), 64'h0);
    rst = 1'b0;
    tick(1);

    // Generator vectors on the 4-byte instance.
    for (int i = 0; i < 10; i++) begin
      if4.en_i = tbl[i].en; if4.mode_i = tbl[i].mode; if4.force_err_i = tbl[i].frc;
      tick(1);
      chk($sformatf("vec%0d_data", i), 64'(if4.tx_data_o), 64'(tbl[i].data));
      chk($sformatf("vec%0d_k", i), 64'(if4.tx_char_is_k_o), 64'(tbl[i].k));
    end
    if4.en_i = 1'b0; if4.force_err_i = 1'b0;

    // Fixed mode, 8 bytes, looped back.
    if8.en_i = 1'b1; if8.mode_i = 2'd0;
    tick(1);
    chk("fix_tx_data", if8.tx_data_o, 64'h4A4A4A4A_4A4A4ABC);
    chk("fix_tx_k", 64'(if8.tx_char_is_k_o), 64'h01);
    tick(9);
    chk("fix_lock_early", 64'(if8.locked_o), 64'h0);
    tick(1);
    chk("fix_lock", 64'(if8.locked_o), 64'h1);
    chk("fix_word_cnt0", 64'(if8.word_cnt_o), 64'h0);
    tick(1);
    chk("fix_word_cnt1", 64'(if8.word_cnt_o), 64'h1);
    chk("fix_err_cnt", 64'(if8.err_cnt_o), 64'h0);

    // One forced TX error.
    if8.force_err_i = 1'b1;
    tick(1);
    if8.force_err_i = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick(1);
      pulses += int'(if8.err_o);
    end
    chk("force_pulses", 64'(pulses), 64'h1);
    chk("force_err_cnt", 64'(if8.err_cnt_o), 64'h1);
    chk("force_locked", 64'(if8.locked_o), 64'h1);

    if8.cnt_clr_i = 1'b1;
    tick(1);
    if8.cnt_clr_i = 1'b0;
    chk("clr_err_cnt", 64'(if8.err_cnt_o), 64'h0);
    chk("clr_word_cnt", 64'(if8.word_cnt_o), 64'h0);

    // Four consecutive bad RX words drop lock, eight clean ones relock.
    corrupt8 = 1'b1;
    tick(3);
    chk("bad3_locked", 64'(if8.locked_o), 64'h1);
    chk("bad3_err_cnt", 64'(if8.err_cnt_o), 64'h3);
    tick(1);
    corrupt8 = 1'b0;
    chk("bad4_locked", 64'(if8.locked_o), 64'h0);
    chk("bad4_err_cnt", 64'(if8.err_cnt_o), 64'h4);
    tick(7);
    chk("relock_early", 64'(if8.locked_o), 64'h0);
    tick(1);
    chk("relock", 64'(if8.locked_o), 64'h1);
    chk("relock_err_cnt", 64'(if8.err_cnt_o), 64'h4);

    // Clear in the same cycle as an error.
    corrupt8 = 1'b1; if8.cnt_clr_i = 1'b1;
    tick(1);
    corrupt8 = 1'b0; if8.cnt_clr_i = 1'b0;
    chk("clr_err_pulse", 64'(if8.err_o), 64'h1);
    chk("clr_same_err_cnt", 64'(if8.err_cnt_o), 64'h0);
    tick(1);
    chk("clr_after_err_cnt", 64'(if8.err_cnt_o), 64'h0);
    chk("clr_after_word_cnt", 64'(if8.word_cnt_o), 64'h1);

    // Asynchronous reset mid-run.
    rst = 1'b1;
    #1;
    chk("mrst_tx_data", if8.tx_data_o, 64'h0);
    chk("mrst_tx_k", 64'(if8.tx_char_is_k_o), 64'h0);
    chk("mrst_locked", 64'(if8.locked_o), 64'h0);
    chk("mrst_word_cnt", 64'(if8.word_cnt_o), 64'h0);
    chk("mrst_state", 64'(u_dut8.state_r), 64'h0);
    #2;
    rst = 1'b0;
    tick(1);
    chk("mrst_rel_err", 64'(if8.err_o), 64'h0);
    chk("mrst_rel_locked", 64'(if8.locked_o), 64'h0);
    if8.en_i = 1'b0;
    tick(1);

    // PRBS-7, 2 bytes.
    if2.en_i = 1'b1; if2.mode_i = 2'd2;
    tick(1);
    chk("prbs_w0", 64'(if2.tx_data_o), 64'h3040);
    tick(1);
    chk("prbs_w1", 64'(if2.tx_data_o), 64'h4F14);
    m = prbs16(7'h7F);
    m = prbs16(m[22:16]);
    m = prbs16(m[22:16]);
    tick(1);
    chk("prbs_w2", 64'(if2.tx_data_o), 64'(m[15:0]));
    for (int i = 0; i < 20; i++) begin
      if (if2.locked_o) break;
      tick(1);
    end
    chk("prbs_lock", 64'(if2.locked_o), 64'h1);
    tick(2);
    flip2 = 1'b1;
    tick(1);
    flip2 = 1'b0;
    tick(4);
    chk("prbs_err_cnt", 64'(if2.err_cnt_o), 64'h1);
    chk("prbs_locked", 64'(if2.locked_o), 64'h1);
    if2.en_i = 1'b0;

    // Counting, 4 bytes, RX starting at an arbitrary offset.
    if4.en_i = 1'b1; if4.mode_i = 2'd1;
    w4 = 0;
    for (int i = 0; i < 20; i++) begin
      if (if4.locked_o) break;
      drive4(w4); w4++;
      tick(1);
    end
    chk("cnt_lock", 64'(if4.locked_o), 64'h1);
    chk("cnt_err_cnt", 64'(if4.err_cnt_o), 64'h0);

    // 20 isolated errors saturate the 4-bit error counter without losing lock.
    for (int e = 0; e < 40; e++) begin
      drive4(w4); w4++;
      if4.rx_not_in_table_i = (e % 2 == 0) ? 4'h1 : 4'h0;
      tick(1);
      if (e == 27) chk("sat_mid_err_cnt", 64'(if4.err_cnt_o), 64'hE);
    end
    if4.rx_not_in_table_i = 4'h0;
    chk("sat_err_cnt", 64'(if4.err_cnt_o), 64'hF);
    chk("sat_locked", 64'(if4.locked_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes_pattern_chk.md
Name: serdes_pattern_chk

Overview:
- Parametrised successor to the fixed-word SERDES loopback stimulus.
- Generates a selectable TX test pattern for CC_SERDES: fixed comma word, counting sequence or PRBS-7, with 2, 4 or 8 bytes per word to match the 20/40/80-bit datapath.
- Checks the returned RX words with a lock FSM, per-word error detection, and saturating error and word counters.
- Sits between the fabric and the CC_SERDES TX/RX data ports. TX and RX ports share one clock; the RX buffer is used, so RX data is synchronous to the TX clock.

Parameters:
- BYTES, 8, bytes per word (2, 4 or 8).
- COMMA_K, 8'hBC, K character placed in fixed mode (K28.5).
- FILL, 8'h4A, filler data byte in fixed mode.
- K_POS, 0, byte lane of the comma in fixed mode (0..BYTES-1).
- ERR_CNT_W, 16, error counter width.
- LOCK_GOOD, 8, consecutive good words needed to lock.
- LOCK_BAD, 4, consecutive bad words that drop lock.

Ports:
- trx_clk_i  in  1  datapath clock; all logic is on its rising edge.
- trx_rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  enables generator and checker.
- mode_i  in  2  0 fixed comma, 1 counting, 2 PRBS-7, 3 reserved (behaves as 0).
- force_err_i  in  1  inverts tx_data_o bit 0 for the word registered in that cycle.
- cnt_clr_i  in  1  synchronous clear of both counters.
- tx_data_o  out  8*BYTES  to TX_DATA_I.
- tx_char_is_k_o  out  BYTES  to TX_CHAR_IS_K_I.
- rx_data_i  in  8*BYTES  from RX_DATA_O.
- rx_char_is_k_i  in  BYTES  per-byte K flag from RX.
- rx_not_in_table_i  in  BYTES  8b/10b code error per byte.
- rx_disp_err_i  in  BYTES  disparity error per byte.
- locked_o  out  1  checker locked.
- err_o  out  1  one-cycle pulse per bad word while locked.
- err_cnt_o  out  ERR_CNT_W  bad words counted while locked, saturating.
- word_cnt_o  out  32  words compared while locked, saturating.

Behaviour:
- Reset: all outputs 0. Generator counting sequence = 0. PRBS TX and RX state = 7'h7F. FSM = IDLE.
- TX outputs are registered, with 1-cycle latency from en_i/mode_i.
- en_i = 0: tx_data_o = 0, tx_char_is_k_o = 0.
- Fixed mode: byte K_POS = COMMA_K with K flag set; all other bytes = FILL with K flag clear. The word is constant every cycle.
- Counting mode: byte i = (seq + i) mod 256; seq advances by BYTES each word; all K flags clear.
- PRBS-7 mode:
  - Polynomial x^7+x^6+1; new bit = s[6]^s[5]; state shifts left with the new bit entering at s[0].
  - Each word consumes 8*BYTES steps; tx_data_o bit j is the bit produced at step j (bit 0 first).
  - All K flags clear.
- force_err_i: XOR applied after pattern generation; does not disturb seq or PRBS state.
- Word error (any one sufficient):
  - data mismatch against the expected word;
  - K flag mismatch against the expected K flags;
  - any rx_not_in_table_i bit set;
  - any rx_disp_err_i bit set.
- FSM states: IDLE, SEARCH, LOCKED.
  - IDLE: entered whenever en_i = 0; go to SEARCH when en_i = 1.
  - SEARCH: each cycle, seed the expectation from the received word. Counting: expected seq = rx byte 0 + BYTES. PRBS: RX state = last 7 received bits. Compare each following word against the expectation; good_cnt +1 per good word, cleared on a bad word. When good_cnt reaches LOCK_GOOD, go to LOCKED. locked_o is registered: high on the cycle after the LOCK_GOOD-th good word.
  - LOCKED: the expectation free-runs and never reseeds. word_cnt +1 per word. On a bad word: err_o pulses the next cycle, err_cnt +1, bad_cnt +1. A good word clears bad_cnt. When bad_cnt reaches LOCK_BAD, go to SEARCH and drop locked_o; the word that triggers the drop is still counted.
- A mode_i change while enabled forces SEARCH, clearing good_cnt and bad_cnt; counters are kept.
- Counters saturate at all-ones.
- cnt_clr_i: clears both counters; takes priority over a same-cycle increment.
- trx_rst_i mid-operation: immediate asynchronous return to reset values; no pulses generated on release.

Test Plan:
- Fixed mode, BYTES=8, tx looped straight to rx with 2-cycle delay -> tx_data_o = 64'h4A4A4A4A_4A4A4ABC, tx_char_is_k_o = 8'h01; locked_o rises 1 cycle after the 8th good word; err_cnt_o stays 0.
- Locked, one-cycle force_err_i -> exactly one err_o pulse; err_cnt_o = 1; locked_o stays high.
- Counting mode, BYTES=4 -> consecutive tx words 32'h03020100, 32'h07060504; rx offset by an arbitrary start still locks; err_cnt_o = 0.
- PRBS-7 mode, BYTES=2 -> first tx word from seed 7F matches the reference model; a single flipped rx bit after lock gives err_cnt_o = 1.
- Corrupt 4 consecutive rx words while locked -> err_cnt_o = 4, locked_o falls, relock after 8 clean words; cnt_clr_i in a same-cycle error leaves err_cnt_o = 0.
- ERR_CNT_W=4 with 20 injected errors -> err_cnt_o saturates at 4'hF; trx_rst_i pulse mid-run -> all outputs 0 and FSM in IDLE.
